// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam logic MASTER_ICACHE = 1'b0;
  localparam logic MASTER_DCACHE = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way tie-break: picks the next master to grant from
// the two request lines and the last granted master.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    grant_o = MASTER_ICACHE;
    if (req0_i && req1_i) begin
      // On a tie, round-robin hands the bus to whoever did not have it last.
      grant_o = (FIXED_PRIORITY != 0) ? MASTER_DCACHE : ~last_grant_i;
    end else if (req1_i) begin
      grant_o = MASTER_DCACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single Avalon-style RAM port between the icache (master 0)
// and dcache (master 1), granting whole transactions one at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_icache,
  input  logic                 write_icache,
  input  logic [31:0]          addr_icache,
  input  logic [3:0]           byteenable_icache,
  input  logic [31:0]          writedata_icache,
  output logic [31:0]          readdata_icache,
  output logic                 waitrequest_icache,
  input  logic                 read_dcache,
  input  logic                 write_dcache,
  input  logic [31:0]          addr_dcache,
  input  logic [3:0]           byteenable_dcache,
  input  logic [31:0]          writedata_dcache,
  output logic [31:0]          readdata_dcache,
  output logic                 waitrequest_dcache,
  output logic                 read_ram,
  output logic                 write_ram,
  output logic [31:0]          addr_ram,
  output logic [3:0]           byteenable_ram,
  output logic [31:0]          writedata_ram,
  input  logic [31:0]          readdata_ram,
  input  logic                 waitrequest_ram,
  output logic [CNT_WIDTH-1:0] contention_count
);

  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic       req0, req1;
  logic       pick_grant, pick_valid;
  logic [1:0] waiting;

  assign req0 = read_icache | write_icache;
  assign req1 = read_dcache | write_dcache;

  rr_pick #(
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_rr_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = (pick_grant == MASTER_DCACHE) ? GRANT1 : GRANT0;
      end
      GRANT0: begin
        if (!req0) begin
          state_d = IDLE;
        end else if (!waitrequest_ram) begin
          last_grant_d = MASTER_ICACHE;
          state_d      = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!waitrequest_ram) begin
          last_grant_d = MASTER_DCACHE;
          state_d      = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A master counts as waiting whenever it requests outside its own grant state.
  always_comb begin
    waiting = 2'(req0 && (state_q != GRANT0)) + 2'(req1 && (state_q != GRANT1));
    count_d = count_q + CNT_WIDTH'(waiting);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= MASTER_DCACHE;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    read_ram           = 1'b0;
    write_ram          = 1'b0;
    addr_ram           = '0;
    byteenable_ram     = '0;
    writedata_ram      = '0;
    readdata_icache    = '0;
    readdata_dcache    = '0;
    waitrequest_icache = 1'b1;
    waitrequest_dcache = 1'b1;
    unique case (state_q)
      GRANT0: begin
        read_ram           = read_icache;
        write_ram          = write_icache;
        addr_ram           = addr_icache;
        byteenable_ram     = byteenable_icache;
        writedata_ram      = writedata_icache;
        readdata_icache    = readdata_ram;
        waitrequest_icache = waitrequest_ram;
      end
      GRANT1: begin
        read_ram           = read_dcache;
        write_ram          = write_dcache;
        addr_ram           = addr_dcache;
        byteenable_ram     = byteenable_dcache;
        writedata_ram      = writedata_dcache;
        readdata_dcache    = readdata_ram;
        waitrequest_dcache = waitrequest_ram;
      end
      default: ;
    endcase
  end

  assign contention_count = count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority
// instance share stimulus; each scenario checks the instance it targets.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_icache, write_icache, read_dcache, write_dcache;
  logic [31:0] addr_icache, writedata_icache, addr_dcache, writedata_dcache;
  logic [3:0]  byteenable_icache, byteenable_dcache;
  logic [31:0] readdata_ram;
  logic        waitrequest_ram;

  logic [31:0] rd_i0, rd_d0, addr0, wd0, cnt0;
  logic        wr_i0, wr_d0, rram0, wram0;
  logic [3:0]  be0;
  logic [31:0] rd_i1, rd_d1, addr1, wd1, cnt1;
  logic        wr_i1, wr_d1, rram1, wram1;
  logic [3:0]  be1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIORITY(0), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset),
    .read_icache(read_icache), .write_icache(write_icache), .addr_icache(addr_icache),
    .byteenable_icache(byteenable_icache), .writedata_icache(writedata_icache),
    .readdata_icache(rd_i0), .waitrequest_icache(wr_i0),
    .read_dcache(read_dcache), .write_dcache(write_dcache), .addr_dcache(addr_dcache),
    .byteenable_dcache(byteenable_dcache), .writedata_dcache(writedata_dcache),
    .readdata_dcache(rd_d0), .waitrequest_dcache(wr_d0),
    .read_ram(rram0), .write_ram(wram0), .addr_ram(addr0), .byteenable_ram(be0),
    .writedata_ram(wd0), .readdata_ram(readdata_ram), .waitrequest_ram(waitrequest_ram),
    .contention_count(cnt0)
  );

  mem_arbiter #(.FIXED_PRIORITY(1), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset),
    .read_icache(read_icache), .write_icache(write_icache), .addr_icache(addr_icache),
    .byteenable_icache(byteenable_icache), .writedata_icache(writedata_icache),
    .readdata_icache(rd_i1), .waitrequest_icache(wr_i1),
    .read_dcache(read_dcache), .write_dcache(write_dcache), .addr_dcache(addr_dcache),
    .byteenable_dcache(byteenable_dcache), .writedata_dcache(writedata_dcache),
    .readdata_dcache(rd_d1), .waitrequest_dcache(wr_d1),
    .read_ram(rram1), .write_ram(wram1), .addr_ram(addr1), .byteenable_ram(be1),
    .writedata_ram(wd1), .readdata_ram(readdata_ram), .waitrequest_ram(waitrequest_ram),
    .contention_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    read_icache = 0; write_icache = 0; addr_icache = '0; byteenable_icache = '0;
    writedata_icache = '0;
    read_dcache = 0; write_dcache = 0; addr_dcache = '0; byteenable_dcache = '0;
    writedata_dcache = '0;
    readdata_ram = '0; waitrequest_ram = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic tie_stimulus();
    read_icache = 1; addr_icache = 32'd16;
    write_dcache = 1; addr_dcache = 32'd32; writedata_dcache = 32'hDEAD_BEEF;
    byteenable_dcache = 4'b0011;
    readdata_ram = 32'h0000_00AA; waitrequest_ram = 0;
  endtask

  initial begin
    // Reset then idle
    do_reset();
    cyc();
    check("idle_read_ram", 32'(rram0), 32'd0);
    check("idle_write_ram", 32'(wram0), 32'd0);
    check("idle_wait_i", 32'(wr_i0), 32'd1);
    check("idle_wait_d", 32'(wr_d0), 32'd1);
    check("idle_cnt", cnt0, 32'd0);

    // Uncontended icache read, zero-wait RAM
    read_icache = 1; addr_icache = 32'd16; readdata_ram = 32'h0000_00AA; waitrequest_ram = 0;
    #1;
    check("rd_c1_wait_i", 32'(wr_i0), 32'd1);
    check("rd_c1_read_ram", 32'(rram0), 32'd0);
    cyc();
    check("rd_c2_read_ram", 32'(rram0), 32'd1);
    check("rd_c2_addr", addr0, 32'd16);
    check("rd_c2_wait_i", 32'(wr_i0), 32'd0);
    check("rd_c2_rdata_i", rd_i0, 32'h0000_00AA);
    cyc();
    read_icache = 0;
    #1;
    check("rd_c3_read_ram", 32'(rram0), 32'd0);
    check("rd_c3_wait_i", 32'(wr_i0), 32'd1);
    check("rd_c3_cnt", cnt0, 32'd1);

    // Tie, round-robin: icache first, then direct switch to dcache
    do_reset();
    tie_stimulus();
    #1;
    check("rr_c1_wait_i", 32'(wr_i0), 32'd1);
    check("rr_c1_wait_d", 32'(wr_d0), 32'd1);
    cyc();
    check("rr_c2_read_ram", 32'(rram0), 32'd1);
    check("rr_c2_addr", addr0, 32'd16);
    check("rr_c2_rdata_i", rd_i0, 32'h0000_00AA);
    check("rr_c2_wait_d", 32'(wr_d0), 32'd1);
    cyc();
    read_icache = 0;
    #1;
    check("rr_c3_write_ram", 32'(wram0), 32'd1);
    check("rr_c3_addr", addr0, 32'd32);
    check("rr_c3_be", 32'(be0), 32'h3);
    check("rr_c3_wdata", wd0, 32'hDEAD_BEEF);
    check("rr_c3_wait_d", 32'(wr_d0), 32'd0);
    check("rr_c3_rdata_i", rd_i0, 32'd0);
    check("rr_c3_cnt", cnt0, 32'd3);
    cyc();
    write_dcache = 0;
    #1;
    check("rr_c4_write_ram", 32'(wram0), 32'd0);
    check("rr_c4_cnt", cnt0, 32'd3);

    // Tie, fixed priority: dcache first, then icache
    do_reset();
    tie_stimulus();
    #1;
    check("fp_c1_wait_d", 32'(wr_d1), 32'd1);
    cyc();
    check("fp_c2_write_ram", 32'(wram1), 32'd1);
    check("fp_c2_read_ram", 32'(rram1), 32'd0);
    check("fp_c2_addr", addr1, 32'd32);
    check("fp_c2_wait_d", 32'(wr_d1), 32'd0);
    check("fp_c2_wait_i", 32'(wr_i1), 32'd1);
    cyc();
    write_dcache = 0;
    #1;
    check("fp_c3_read_ram", 32'(rram1), 32'd1);
    check("fp_c3_addr", addr1, 32'd16);
    check("fp_c3_rdata_i", rd_i1, 32'h0000_00AA);
    check("fp_c3_cnt", cnt1, 32'd3);
    cyc();
    read_icache = 0;
    #1;
    check("fp_c4_read_ram", 32'(rram1), 32'd0);
    check("fp_c4_cnt", cnt1, 32'd3);

    // dcache read stalled 5 cycles by RAM while icache waits
    do_reset();
    read_dcache = 1; addr_dcache = 32'h40; waitrequest_ram = 1; readdata_ram = 32'h55;
    cyc();
    read_icache = 1; addr_icache = 32'h80;
    #1;
    for (int unsigned k = 0; k < 5; k++) begin
      check("st_wait_d", 32'(wr_d0), 32'd1);
      check("st_wait_i", 32'(wr_i0), 32'd1);
      check("st_cnt", cnt0, 32'd1 + k);
      check("st_addr", addr0, 32'h40);
      cyc();
    end
    waitrequest_ram = 0;
    #1;
    check("st_done_wait_d", 32'(wr_d0), 32'd0);
    check("st_done_rdata_d", rd_d0, 32'h55);
    check("st_done_cnt", cnt0, 32'd6);
    cyc();
    read_dcache = 0;
    #1;
    check("st_next_read_ram", 32'(rram0), 32'd1);
    check("st_next_addr", addr0, 32'h80);
    check("st_next_cnt", cnt0, 32'd7);
    cyc();
    read_icache = 0;

    // Reset while GRANT1 is stalled on a write
    write_dcache = 1; addr_dcache = 32'd32; waitrequest_ram = 1;
    cyc();
    check("rs_pre_write_ram", 32'(wram0), 32'd1);
    reset = 1;
    cyc();
    reset = 0;
    #1;
    check("rs_write_ram", 32'(wram0), 32'd0);
    check("rs_cnt", cnt0, 32'd0);
    check("rs_wait_i", 32'(wr_i0), 32'd1);
    check("rs_wait_d", 32'(wr_d0), 32'd1);
    clear_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
